// File: rtl/conv1d_mac_scheduler.sv
// Conv1D (kernel 5, stride 1) multiply-stage sequencer: sliding window, weight ROM addressing, requantisation.
// Optional fused ReLU on the requantised result when CONV_RELU_EN is defined.
module conv1d_mac_scheduler #(
  parameter int BIT_WIDTH   = 16,
  parameter int NUM_FILTERS = 8,
  parameter int FRAC_BITS   = 8,
  parameter int LEN_WIDTH   = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [LEN_WIDTH-1:0]              seq_len,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BIT_WIDTH-1:0]              in_data,
  output logic [$clog2(NUM_FILTERS)-1:0]    weight_addr,
  output logic [1:0]                        mul_enable,
  output logic [5*BIT_WIDTH-1:0]            tap_data,
  input  logic [12*BIT_WIDTH-1:0]           mul_results,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BIT_WIDTH-1:0]              out_data,
  output logic [$clog2(NUM_FILTERS)-1:0]    out_filter,
  output logic                              busy,
  output logic                              done
);

  localparam int FW    = $clog2(NUM_FILTERS);
  localparam int PW    = 2 * BIT_WIDTH;
  localparam int ACC_W = PW + 3;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (BIT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (BIT_WIDTH - 1)));

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ADDR = 3'd2,
    S_MAC  = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic [BIT_WIDTH-1:0]     win_q [5];
  logic [BIT_WIDTH-1:0]     win_d [5];
  logic [2:0]               need_q, need_d;
  logic [LEN_WIDTH-1:0]     pos_left_q, pos_left_d;
  logic [FW-1:0]            filt_q, filt_d;
  logic [FW-1:0]            waddr_q, waddr_d;
  logic [FW-1:0]            ofilt_q, ofilt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum_s;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [1:0]               mul_en_q, mul_en_d;
  logic                     seq_ok_s;
  logic                     last_filt_s;

  // Arithmetic shift floors toward -inf; the result is then clamped to the sample range.
  function automatic logic [BIT_WIDTH-1:0] requant(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    logic [BIT_WIDTH-1:0]    r;
    sh = a >>> FRAC_BITS;
    if (sh > SAT_MAX) begin
      r = SAT_MAX[BIT_WIDTH-1:0];
    end else if (sh < SAT_MIN) begin
      r = SAT_MIN[BIT_WIDTH-1:0];
    end else begin
      r = sh[BIT_WIDTH-1:0];
    end
`ifdef CONV_RELU_EN
    if (r[BIT_WIDTH-1]) begin
      r = '0;
    end else begin
      r = r;
    end
`endif
    return r;
  endfunction

  assign seq_ok_s    = (seq_len >= LEN_WIDTH'(5));
  assign last_filt_s = (filt_q == FW'(NUM_FILTERS - 1));

  always_comb begin
    acc_sum_s = '0;
    for (int i = 0; i < 6; i++) begin
      acc_sum_s = acc_sum_s + ACC_W'($signed(mul_results[i*PW +: PW]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = seq_ok_s ? S_LOAD : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_valid && (need_q == 3'd1)) begin
          state_d = S_ADDR;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_ADDR: state_d = S_MAC;
      S_MAC:  state_d = S_OUT;
      S_OUT: begin
        if (!out_ready) begin
          state_d = S_OUT;
        end else if (!last_filt_s) begin
          state_d = S_ADDR;
        end else if (pos_left_q > LEN_WIDTH'(1)) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    mul_en_d    = (state_d == S_MAC) ? 2'b01 : 2'b00;
  end

  always_comb begin
    win_d      = win_q;
    need_d     = need_q;
    pos_left_d = pos_left_q;
    filt_d     = filt_q;
    waddr_d    = waddr_q;
    ofilt_d    = ofilt_q;
    acc_d      = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start && seq_ok_s) begin
          pos_left_d = seq_len - LEN_WIDTH'(4);
          need_d     = 3'd5;
          filt_d     = '0;
          waddr_d    = '0;
        end else begin
          pos_left_d = pos_left_q;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          for (int i = 0; i < 4; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[4] = in_data;
          // After the first window only one new sample completes each position.
          if (need_q == 3'd1) begin
            filt_d  = '0;
            waddr_d = '0;
          end else begin
            need_d = need_q - 3'd1;
          end
        end else begin
          win_d = win_q;
        end
      end
      S_MAC: begin
        acc_d   = acc_sum_s;
        ofilt_d = filt_q;
      end
      S_OUT: begin
        if (out_ready) begin
          if (!last_filt_s) begin
            filt_d  = filt_q + FW'(1);
            waddr_d = filt_q + FW'(1);
          end else begin
            filt_d     = '0;
            waddr_d    = '0;
            pos_left_d = pos_left_q - LEN_WIDTH'(1);
          end
        end else begin
          filt_d = filt_q;
        end
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        win_q[i] <= '0;
      end
      need_q      <= 3'd0;
      pos_left_q  <= '0;
      filt_q      <= '0;
      waddr_q     <= '0;
      ofilt_q     <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mul_en_q    <= 2'b00;
    end else begin
      win_q       <= win_d;
      need_q      <= need_d;
      pos_left_q  <= pos_left_d;
      filt_q      <= filt_d;
      waddr_q     <= waddr_d;
      ofilt_q     <= ofilt_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mul_en_q    <= mul_en_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign mul_enable  = mul_en_q;
  assign weight_addr = waddr_q;
  assign out_filter  = ofilt_q;
  // Held in acc_q, so the word stays stable for the whole OUT stall.
  assign out_data    = requant(acc_q);
  assign tap_data    = {win_q[4], win_q[3], win_q[2], win_q[1], win_q[0]};

endmodule

// File: tb/tb_conv1d_mac_scheduler.sv
// Self-checking bench for conv1d_mac_scheduler: registered weight ROM + multiplier models, arithmetic reference.
module tb_conv1d_mac_scheduler;

  logic         clk, rst, start;
  logic [9:0]   seq_len;
  logic         in_valid, in_ready;
  logic [15:0]  in_data;
  logic [2:0]   weight_addr;
  logic [1:0]   mul_enable;
  logic [79:0]  tap_data;
  logic [191:0] mul_results;
  logic         out_valid, out_ready;
  logic [15:0]  out_data;
  logic [2:0]   out_filter;
  logic         busy, done;

  conv1d_mac_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .weight_addr(weight_addr), .mul_enable(mul_enable), .tap_data(tap_data),
    .mul_results(mul_results), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_filter(out_filter), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] wt [8][5];
  logic signed [15:0] bias [8];
  logic signed [15:0] smp [$];
  logic [15:0]        exp_d [$];
  logic [2:0]         exp_f [$];
  logic [2:0]         rom_addr_q;
  longint             tb_p;
  int                 n_checks, n_pass;
  logic [15:0]        first_d;
  logic [2:0]         first_f;

  // Registered weight ROM plus combinational multiply stage
  always @(posedge clk) rom_addr_q <= weight_addr;
  always_comb begin
    mul_results = '0;
    tb_p = longint'(bias[rom_addr_q]) * 256;
    mul_results[31:0] = tb_p[31:0];
    for (int k = 0; k < 5; k++) begin
      tb_p = longint'($signed(tap_data[k*16 +: 16])) * longint'(wt[rom_addr_q][k]);
      mul_results[(k+1)*32 +: 32] = tb_p[31:0];
    end
  end

  task automatic build_model(input int n);
    longint s;
    exp_d.delete();
    exp_f.delete();
    for (int p = 0; p + 5 <= n; p++) begin
      for (int f = 0; f < 8; f++) begin
        s = longint'(bias[f]) * 256;
        for (int k = 0; k < 5; k++) s += longint'(smp[p+k]) * longint'(wt[f][k]);
        s = s >>> 8;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        exp_d.push_back(16'(s));
        exp_f.push_back(3'(f));
      end
    end
  endtask

  task automatic rand_weights(input int mag);
    int v;
    for (int f = 0; f < 8; f++) begin
      v = int'($urandom_range(0, 2*mag)) - mag;
      bias[f] = 16'(v);
      for (int k = 0; k < 5; k++) begin
        v = int'($urandom_range(0, 2*mag)) - mag;
        wt[f][k] = 16'(v);
      end
    end
  endtask

  task automatic rand_samples(input int n, input int mag);
    int v;
    smp.delete();
    for (int i = 0; i < n; i++) begin
      v = int'($urandom_range(0, 2*mag)) - mag;
      smp.push_back(16'(v));
    end
  endtask

  task automatic run_seq(input int n, input int in_pct, input int rdy_pct,
                         input int stall_at, input int rst_at, input bit spur);
    int sidx, oidx, cyc, last_acc, first_cyc;
    bit done_seen, aborted, ready_seen, stalled;
    logic [15:0] hold_d;
    logic [2:0]  hold_f, hold_wa;
    build_model(n);
    sidx = 0; oidx = 0; cyc = 0; last_acc = -10; first_cyc = -1;
    done_seen = 0; aborted = 0; ready_seen = 0; stalled = 0;
    @(negedge clk);
    seq_len = 10'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 3000 && !done_seen && !aborted) begin
      if (done) begin
        done_seen = 1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      end else begin
        start = 1'b0;
        if (spur && $urandom_range(0, 5) == 0) begin
          start = 1'b1; seq_len = 10'd3;
        end
        if (in_ready) ready_seen = 1;
        in_valid = ($urandom_range(0, 99) < in_pct);
        in_data = (sidx < smp.size()) ? smp[sidx] : 16'($urandom);
        if (in_valid && in_ready) sidx++;
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        if (out_valid) begin
          if (first_cyc < 0) first_cyc = cyc;
          if (oidx == rst_at) begin
            rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({in_ready, out_valid, done, busy, mul_enable} !== 6'd0 || out_data !== 16'd0 ||
                out_filter !== 3'd0 || weight_addr !== 3'd0 || tap_data !== 80'd0)
              $display("FAIL midrun_reset: rdy=%b ov=%b dn=%b bsy=%b me=%b od=%h of=%0d wa=%0d taps=%h, all required 0",
                       in_ready, out_valid, done, busy, mul_enable, out_data, out_filter, weight_addr, tap_data);
            else n_pass++;
            rst = 1'b0;
            aborted = 1;
          end else begin
            if (oidx == stall_at && !stalled) begin
              stalled = 1; out_ready = 1'b0; in_valid = 1'b1;
              hold_d = out_data; hold_f = out_filter; hold_wa = weight_addr;
              repeat (3) begin
                start = 1'b1; seq_len = 10'd3;
                @(negedge clk);
                cyc++;
                start = 1'b0;
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== hold_d || out_filter !== hold_f ||
                    in_ready !== 1'b0 || mul_enable !== 2'b00 || weight_addr !== hold_wa)
                  $display("FAIL stall_hold: ov=%b od=%h of=%0d rdy=%b me=%b wa=%0d, required 1 %h %0d 0 00 %0d",
                           out_valid, out_data, out_filter, in_ready, mul_enable, weight_addr, hold_d, hold_f, hold_wa);
                else n_pass++;
              end
              in_valid = 1'b0; out_ready = 1'b1;
            end
            if (out_ready) begin
              n_checks++;
              if (oidx >= exp_d.size())
                $display("FAIL extra_output: got %h filter %0d, required no more outputs", out_data, out_filter);
              else if (out_data !== exp_d[oidx] || out_filter !== exp_f[oidx])
                $display("FAIL output[%0d]: got %h filter %0d, required %h filter %0d",
                         oidx, out_data, out_filter, exp_d[oidx], exp_f[oidx]);
              else n_pass++;
              if (oidx == 0) begin first_d = out_data; first_f = out_filter; end
              if (rdy_pct == 100 && in_pct == 100 && stall_at < 0 && oidx % 8 != 0) begin
                n_checks++;
                if (cyc - last_acc !== 3) $display("FAIL throughput: gap %0d cycles, required 3", cyc - last_acc);
                else n_pass++;
              end
              last_acc = cyc;
              oidx++;
            end
          end
        end
        if (!aborted) begin
          @(negedge clk);
          cyc++;
        end
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    if (!aborted) begin
      n_checks++;
      if (!done_seen) $display("FAIL done_seen: no done pulse within %0d cycles, required one", cyc);
      else n_pass++;
      n_checks++;
      if (oidx !== exp_d.size()) $display("FAIL output_count: got %0d, required %0d", oidx, exp_d.size());
      else n_pass++;
      n_checks++;
      if (sidx !== ((n >= 5) ? n : 0)) $display("FAIL samples_consumed: got %0d, required %0d", sidx, (n >= 5) ? n : 0);
      else n_pass++;
      if (n < 5) begin
        n_checks++;
        if (ready_seen || cyc > 1) $display("FAIL short_seq: in_ready seen=%0d done after %0d cycles, required 0 and <=1", ready_seen, cyc);
        else n_pass++;
      end else if (in_pct == 100) begin
        n_checks++;
        if (first_cyc !== 7) $display("FAIL first_latency: first out_valid at %0d, required 7", first_cyc);
        else n_pass++;
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL done_pulse: done=%b busy=%b after pulse, required 0 0", done, busy);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, done, busy} !== 4'b0000) $display("FAIL reset_flags: got %b, required 0000", {in_ready, out_valid, done, busy});
    else n_pass++;
    n_checks++;
    if (out_data !== 16'd0 || out_filter !== 3'd0) $display("FAIL reset_out: got %h/%0d, required 0000/0", out_data, out_filter);
    else n_pass++;
    n_checks++;
    if (weight_addr !== 3'd0 || mul_enable !== 2'b00) $display("FAIL reset_mul: wa=%0d me=%b, required 0 00", weight_addr, mul_enable);
    else n_pass++;
    n_checks++;
    if (tap_data !== 80'd0) $display("FAIL reset_taps: got %h, required 0", tap_data);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic(input logic [15:0] b0, input logic [15:0] want);
    rand_weights(16'h0200);
    for (int k = 0; k < 5; k++) wt[0][k] = 16'sh0100;
    bias[0] = b0;
    smp.delete();
    for (int i = 0; i < 5; i++) smp.push_back(16'sh0100);
    run_seq(5, 100, 100, -1, -1, 1'b0);
    n_checks++;
    if (first_d !== want || first_f !== 3'd0) $display("FAIL basic_first: got %h/%0d, required %h/0", first_d, first_f, want);
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [15:0] neg_want;
`ifdef CONV_RELU_EN
    neg_want = 16'h0000;
`else
    neg_want = 16'h8000;
`endif
    for (int f = 0; f < 8; f++) begin
      bias[f] = 16'sh0000;
      for (int k = 0; k < 5; k++) wt[f][k] = 16'sh7FFF;
    end
    smp.delete();
    for (int i = 0; i < 5; i++) smp.push_back(16'sh7FFF);
    run_seq(5, 100, 100, -1, -1, 1'b0);
    n_checks++;
    if (first_d !== 16'h7FFF) $display("FAIL sat_pos: got %h, required 7fff", first_d);
    else n_pass++;
    smp.delete();
    for (int i = 0; i < 5; i++) smp.push_back(16'sh8000);
    run_seq(5, 80, 80, -1, -1, 1'b0);
    n_checks++;
    if (first_d !== neg_want) $display("FAIL sat_neg: got %h, required %h", first_d, neg_want);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    rand_weights(16'h0300);
    rand_samples(7, 16'h0400);
    run_seq(7, 70, 60, 3, -1, 1'b1);
  endtask

  task automatic test_short();
    rand_samples(4, 16'h0100);
    run_seq(3, 100, 100, -1, -1, 1'b0);
    run_seq(4, 100, 100, -1, -1, 1'b0);
  endtask

  task automatic test_reset_midrun();
    rand_weights(16'h0200);
    rand_samples(6, 16'h0200);
    run_seq(6, 100, 100, -1, 8, 1'b0);
    test_basic(16'h0000, 16'h0500);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      rand_weights((it == 3) ? 16'h7FFF : 16'h0400);
      rand_samples(10, (it == 3) ? 16'h7FFF : 16'h0600);
      run_seq(int'($urandom_range(5, 10)), int'($urandom_range(50, 100)), int'($urandom_range(40, 100)), -1, -1, 1'b1);
    end
    rand_samples(8, 16'h0500);
    run_seq(8, 100, 100, -1, -1, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; seq_len = 10'd0; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0;
    first_d = 16'd0; first_f = 3'd0;
    for (int f = 0; f < 8; f++) begin
      bias[f] = 16'sh0000;
      for (int k = 0; k < 5; k++) wt[f][k] = 16'sh0000;
    end
    test_reset();
    test_basic(16'h0000, 16'h0500);
    test_basic(16'h0080, 16'h0580);
    test_saturation();
    test_backpressure();
    test_short();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
